// File: rtl/axi_xdma_st_pkg.sv
// rtl/axi_xdma_st_pkg.sv - shared constants and types for the C2H pattern source
package axi_xdma_st_pkg;

    // config_reg0 field positions
    localparam int EN_BIT   = 0;
    localparam int CONT_BIT = 1;
    localparam int GAP_LSB  = 8;
    localparam int GAP_MSB  = 15;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        GAP
    } state_t;

    // Number of 32-bit pattern lanes in one beat
    function automatic int lanes_of(input int data_w);
        return data_w / 32;
    endfunction

endpackage

// File: rtl/axis_pattern_lanes.sv
// rtl/axis_pattern_lanes.sv - expands one base word into LANES consecutive 32-bit words
module axis_pattern_lanes #(
    parameter int LANES = 2
) (
    input  logic [31:0]         base_i,
    output logic [LANES*32-1:0] data_o
);

    // lane k carries base + k, wrapping modulo 2^32
    always_comb begin
        data_o = '0;
        for (int k = 0; k < LANES; k++) begin
            data_o[32*k +: 32] = base_i + 32'(k);
        end
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI4-Stream incrementing-word packet source for the C2H port
module axis_pattern_gen
    import axi_xdma_st_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                axi_clk,
    input  logic                axi_rst,
    input  logic [31:0]         config_reg0,
    input  logic [31:0]         config_reg1,
    input  logic [31:0]         config_reg2,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                len_err,
    output logic [CNT_W-1:0]    pkt_count
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int GAP_W = GAP_MSB - GAP_LSB + 1;

    state_t             state_q, state_d;
    logic               en_q, en_qq;
    logic [31:0]        word_q, word_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic               len_err_q, len_err_d;
    logic               start, valid, accept, last_beat, keep_going;
    logic [DATA_W-1:0]  lanes_data;
    logic               unused_cfg;

    assign unused_cfg = ^{config_reg0[31:GAP_MSB+1], config_reg0[GAP_LSB-1:CONT_BIT+1],
                          config_reg1[31:LEN_W]};

    assign start      = en_q & ~en_qq;
    assign valid      = (state_q == STREAM);
    assign accept     = valid & m_axis_tready;
    assign last_beat  = (beat_q == len_q - LEN_W'(1));
    assign keep_going = mode_q & en_q;

    axis_pattern_lanes #(.LANES(LANES)) u_lanes (
        .base_i (word_q),
        .data_o (lanes_data)
    );

    // Registered enable plus its delayed copy for rising-edge detection
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            en_q  <= 1'b0;
            en_qq <= 1'b0;
        end else begin
            en_q  <= config_reg0[EN_BIT];
            en_qq <= en_q;
        end
    end

    // Next-state logic: the LOAD cycle doubles as the last gap cycle, so GAP lasts gap-1 cycles
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        len_d       = len_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        mode_d      = mode_q;
        pkt_count_d = pkt_count_q;
        len_err_d   = len_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d      = config_reg2;
                    pkt_count_d = '0;
                    len_err_d   = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                len_d  = config_reg1[LEN_W-1:0];
                gap_d  = config_reg0[GAP_MSB:GAP_LSB];
                mode_d = config_reg0[CONT_BIT];
                beat_d = '0;
                if (!en_q) begin
                    state_d = IDLE;
                end else if (len_d == '0) begin
                    len_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    word_d = word_q + 32'(LANES);
                    if (last_beat) begin
                        beat_d      = '0;
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                        if (gap_q > GAP_W'(1)) begin
                            gap_cnt_d = gap_q - GAP_W'(2);
                            state_d   = GAP;
                        end else begin
                            state_d = keep_going ? LOAD : IDLE;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = keep_going ? LOAD : IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en_q) begin
            len_err_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= 1'b0;
            pkt_count_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            mode_q      <= mode_d;
            pkt_count_q <= pkt_count_d;
            len_err_q   <= len_err_d;
        end
    end

    assign m_axis_tvalid = valid;
    assign m_axis_tdata  = valid ? lanes_data : '0;
    assign m_axis_tkeep  = {(DATA_W/8){valid}};
    assign m_axis_tlast  = valid & last_beat;
    assign busy          = (state_q != IDLE);
    assign len_err       = len_err_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - self-checking bench for axis_pattern_gen
module tb_axis_pattern_gen;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic [31:0] config_reg0, config_reg1, config_reg2;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic        busy, len_err;
    logic [31:0] pkt_count;

    axis_pattern_gen #(.DATA_W(64), .LEN_W(16), .CNT_W(32)) dut (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .config_reg0   (config_reg0),
        .config_reg1   (config_reg1),
        .config_reg2   (config_reg2),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .len_err       (len_err),
        .pkt_count     (pkt_count)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [31:0] seed;
        int          len;
        logic [31:0] last_lane1;
    } vec_t;

    vec_t        vecs[4];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_word;
    logic [31:0] last_lane1;
    int          cur_len, beat_in_pkt, pkts_done, beats_total, idle_run, last_gap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Evaluate the current cycle at a negedge, then move to the next negedge
    task automatic step(input bit rnd);
        m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axis_tvalid) begin
            if (idle_run >= 0) begin
                last_gap = idle_run;
                idle_run = -1;
            end
            check("lane0", {32'h0, m_axis_tdata[31:0]}, {32'h0, exp_word});
            check("lane1", {32'h0, m_axis_tdata[63:32]}, {32'h0, exp_word + 32'd1});
            check("tlast", 64'(m_axis_tlast), 64'(beat_in_pkt == cur_len - 1));
            check("tkeep", 64'(m_axis_tkeep), 64'hFF);
            if (m_axis_tready) begin
                beats_total++;
                last_lane1 = m_axis_tdata[63:32];
                exp_word   = exp_word + 32'd2;
                if (m_axis_tlast) begin
                    pkts_done++;
                    beat_in_pkt = 0;
                    idle_run    = 0;
                end else begin
                    beat_in_pkt++;
                end
            end
        end else if (idle_run >= 0) begin
            idle_run++;
        end
        @(negedge axi_clk);
    endtask

    // Program config with enable low, then raise enable; optionally measure start latency
    task automatic start(input logic [31:0] seed, input int len, input int gap, input bit cont,
                         input bit expect_stream);
        int lat, i;
        config_reg0 = {16'h0, 8'(gap), 6'b0, cont, 1'b0};
        config_reg1 = 32'(len);
        config_reg2 = seed;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge axi_clk);
        config_reg0[0] = 1'b1;
        cur_len = len; exp_word = seed; beat_in_pkt = 0; pkts_done = 0;
        beats_total = 0; idle_run = -1; last_gap = -1;
        if (expect_stream) begin
            lat = 0;
            i   = 0;
            while (lat == 0 && i < 8) begin
                @(negedge axi_clk);
                i++;
                if (m_axis_tvalid) lat = i;
            end
            check("start_latency", 64'(lat), 64'd3);
        end
    endtask

    task automatic run_until_pkts(input int n, input bit rnd, input int budget);
        int c = 0;
        while (pkts_done < n && c < budget) begin
            step(rnd);
            c++;
        end
        check("pkts_done", 64'(pkts_done), 64'(n));
    endtask

    initial begin
        int nv, c;
        vecs[0] = '{32'h0000_0100, 4, 32'h0000_0107};
        vecs[1] = '{32'hFFFF_FFFE, 2, 32'h0000_0001};
        vecs[2] = '{32'h0000_0005, 1, 32'h0000_0006};
        vecs[3] = '{32'hDEAD_0000, 3, 32'hDEAD_0005};

        axi_rst = 1'b1;
        config_reg0 = '0; config_reg1 = '0; config_reg2 = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge axi_clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        axi_rst = 1'b0;
        @(negedge axi_clk);

        // One-shot packets, full-rate ready
        for (int v = 0; v < 4; v++) begin
            start(vecs[v].seed, vecs[v].len, 0, 1'b0, 1'b1);
            run_until_pkts(1, 1'b0, 40);
            check("oneshot_beats", 64'(beats_total), 64'(vecs[v].len));
            check("oneshot_last_word", 64'(last_lane1), 64'(vecs[v].last_lane1));
            check("oneshot_pkt_count", 64'(pkt_count), 64'd1);
            check("oneshot_busy_after", 64'(busy), 64'd0);
        end

        // Random backpressure: lane checks against the model cover stability and contiguity
        start(32'h0000_1000, 8, 0, 1'b0, 1'b1);
        run_until_pkts(1, 1'b1, 200);
        check("bp_beats", 64'(beats_total), 64'd8);
        check("bp_last_word", 64'(last_lane1), 64'h100F);
        check("bp_pkt_count", 64'(pkt_count), 64'd1);

        // Continuous with gap=3, len=2
        start(32'h0000_0040, 2, 3, 1'b1, 1'b1);
        run_until_pkts(3, 1'b0, 60);
        check("cont_gap", 64'(last_gap), 64'd3);
        check("cont_pkt_count", 64'(pkt_count), 64'd3);
        check("cont_last_word", 64'(last_lane1), 64'h4B);
        c = 0;
        while (!m_axis_tvalid && c < 10) begin
            step(1'b0);
            c++;
        end
        check("cont_restart_valid", 64'(m_axis_tvalid), 64'd1);
        config_reg0[0] = 1'b0;
        run_until_pkts(4, 1'b0, 20);
        check("drop_pkt_count", 64'(pkt_count), 64'd4);
        repeat (6) step(1'b0);
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_beats", 64'(beats_total), 64'd8);
        check("drop_last_word", 64'(last_lane1), 64'h4F);

        // Zero length start
        start(32'h0, 0, 0, 1'b0, 1'b0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid) nv++;
            step(1'b0);
        end
        check("len0_no_valid", 64'(nv), 64'd0);
        check("len0_len_err", 64'(len_err), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        config_reg0[0] = 1'b0;
        repeat (3) step(1'b0);
        check("len0_err_cleared", 64'(len_err), 64'd0);

        // Reset on beat 3 of 6, then a fresh start from the seed
        start(32'h0000_2000, 6, 0, 1'b0, 1'b1);
        c = 0;
        while (beat_in_pkt < 2 && c < 20) begin
            step(1'b0);
            c++;
        end
        axi_rst = 1'b1;
        config_reg0 = '0;
        @(negedge axi_clk);
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        axi_rst = 1'b0;
        @(negedge axi_clk);
        start(32'h0000_2000, 6, 0, 1'b0, 1'b1);
        run_until_pkts(1, 1'b0, 40);
        check("rerun_beats", 64'(beats_total), 64'd6);
        check("rerun_last_word", 64'(last_lane1), 64'h200B);
        check("rerun_pkt_count", 64'(pkt_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
